estacao_reserva_ls: RTL

//  Load/store reservation station: upstream feeder of the type-I functional unit (load/store FU).

---
 rtl/estacao_reserva_ls.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/estacao_reserva_ls.sv
// Load/store reservation station: in-order queue feeding the load/store FU.
// Snoops the CDB for pending operands and runs the Ready_to_uf/Done/Clear handshake.
module estacao_reserva_ls #(
    parameter int DEPTH    = 3,
    parameter int TAG_W    = 3,
    parameter int TAG_BASE = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Issue_valid,
    output logic             Issue_ready,
    input  logic [2:0]       Issue_ufop,
    input  logic [15:0]      Issue_vj,
    input  logic [TAG_W-1:0] Issue_qj,
    input  logic [15:0]      Issue_imm,
    input  logic [15:0]      Issue_vk,
    input  logic [TAG_W-1:0] Issue_qk,
    output logic [TAG_W-1:0] Issue_tag,
    input  logic             CDB_valid,
    input  logic [TAG_W-1:0] CDB_tag,
    input  logic [15:0]      CDB_data,
    output logic [15:0]      Op1,
    output logic [15:0]      Op2,
    output logic [15:0]      Op3,
    output logic [2:0]       Ufop,
    output logic             Ready_to_uf,
    output logic             Clear,
    input  logic             Done,
    output logic [TAG_W-1:0] Exec_tag,
    output logic [2:0]       Count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [2:0] OP_LOAD  = 3'd4;
    localparam logic [2:0] OP_STORE = 3'd5;

    typedef enum logic [1:0] {IDLE, EXEC, CLR} state_t;

    state_t state, state_n;

    logic [DEPTH-1:0] e_valid;
    logic [2:0]       e_ufop [DEPTH];
    logic [15:0]      e_vj   [DEPTH];
    logic [TAG_W-1:0] e_qj   [DEPTH];
    logic [15:0]      e_imm  [DEPTH];
    logic [15:0]      e_vk   [DEPTH];
    logic [TAG_W-1:0] e_qk   [DEPTH];

    logic [PW-1:0] head, tail, head_n, tail_n;
    logic          accept, pop, dispatch, head_rdy;
    logic          hit_j, hit_k;

    assign Issue_ready = (Count < 3'(DEPTH));
    assign Issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(tail);
    assign accept      = Issue_valid && Issue_ready &&
                         (Issue_ufop == OP_LOAD || Issue_ufop == OP_STORE);
    assign hit_j  = CDB_valid && (Issue_qj != '0) && (CDB_tag == Issue_qj);
    assign hit_k  = CDB_valid && (Issue_qk != '0) && (CDB_tag == Issue_qk);
    assign head_n = (head == PW'(DEPTH-1)) ? '0 : head + 1'b1;
    assign tail_n = (tail == PW'(DEPTH-1)) ? '0 : tail + 1'b1;
    assign head_rdy = e_valid[head] && (e_qj[head] == '0) &&
                      (e_ufop[head] == OP_LOAD || e_qk[head] == '0);

    // FSM state register
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_n;
    end

    // Next state: dispatch only the oldest entry, pop on Done
    always_comb begin
        state_n  = state;
        dispatch = 1'b0;
        pop      = 1'b0;
        unique case (state)
            IDLE: if (Count != 3'd0 && head_rdy) begin
                dispatch = 1'b1;
                state_n  = EXEC;
            end
            EXEC: if (Done) begin
                pop     = 1'b1;
                state_n = CLR;
            end
            CLR:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Queue storage, pointers, occupancy and CDB snoop
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            head    <= '0;
            tail    <= '0;
            Count   <= '0;
            e_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_ufop[i] <= '0;
                e_vj[i]   <= '0;
                e_qj[i]   <= '0;
                e_imm[i]  <= '0;
                e_vk[i]   <= '0;
                e_qk[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (e_valid[i] && CDB_valid) begin
                    if (e_qj[i] != '0 && e_qj[i] == CDB_tag) begin
                        e_vj[i] <= CDB_data;
                        e_qj[i] <= '0;
                    end
                    if (e_qk[i] != '0 && e_qk[i] == CDB_tag) begin
                        e_vk[i] <= CDB_data;
                        e_qk[i] <= '0;
                    end
                end
            end
            if (accept) begin
                e_valid[tail] <= 1'b1;
                e_ufop[tail]  <= Issue_ufop;
                e_vj[tail]    <= hit_j ? CDB_data : Issue_vj;
                e_qj[tail]    <= hit_j ? '0 : Issue_qj;
                e_imm[tail]   <= Issue_imm;
                e_vk[tail]    <= hit_k ? CDB_data : Issue_vk;
                e_qk[tail]    <= hit_k ? '0 : Issue_qk;
                tail          <= tail_n;
            end
            if (pop) begin
                e_valid[head] <= 1'b0;
                head          <= head_n;
            end
            Count <= Count + 3'(accept) - 3'(pop);
        end
    end

    // FU interface registers and handshake
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            Op1         <= '0;
            Op2         <= '0;
            Op3         <= '0;
            Ufop        <= '0;
            Exec_tag    <= '0;
            Ready_to_uf <= 1'b0;
            Clear       <= 1'b0;
        end else begin
            if (dispatch) begin
                Op1         <= e_vj[head];
                Op2         <= e_imm[head];
                Op3         <= e_vk[head];
                Ufop        <= e_ufop[head];
                Exec_tag    <= TAG_W'(TAG_BASE) + TAG_W'(head);
                Ready_to_uf <= 1'b1;
            end
            if (pop) begin
                Ready_to_uf <= 1'b0;
                Clear       <= 1'b1;
            end
            if (state == CLR) Clear <= 1'b0;
        end
    end

endmodule
